// File: rtl/clint_unit.sv
// clint_unit: core-local interruptor with a 64-bit mtime/mtimecmp timer pair,
// a software-interrupt bit (msip) and a synchronizer for the external
// interrupt line. Exposes a single-outstanding MMIO request/response port.
module clint_unit #(
    parameter int unsigned TICK_DIV        = 1,  // clk cycles per mtime increment
    parameter int unsigned EXT_SYNC_STAGES = 2   // depth of the exint_raw synchronizer
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_strb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    input  logic        exint_raw,
    output logic        trint,
    output logic        swint,
    output logic        exint
);

    localparam logic [15:0] ADDR_MSIP     = 16'h0000;
    localparam logic [15:0] ADDR_MTIMECMP = 16'h4000;
    localparam logic [15:0] ADDR_MTIME    = 16'hBFF8;
    localparam logic [15:0] PRESC_MAX     = 16'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_MTIMECMP,
        SEL_MTIME
    } reg_sel_e;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_v;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_v[8*i +: 8];
        end
        return merged;
    endfunction

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [15:0] r_presc;
    logic        r_trint;
    logic        r_resp_valid;
    logic [63:0] r_resp_rdata;
    logic        r_resp_err;
    logic [EXT_SYNC_STAGES-1:0] r_sync;

    reg_sel_e    w_sel;
    logic        w_err;
    logic        w_accept;
    logic        w_wr_en;
    logic        w_tick;
    logic [15:0] w_presc_nxt;
    logic [63:0] w_mtime_inc;
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_mtimecmp_nxt;
    logic        w_msip_nxt;
    logic [63:0] w_rdata_sel;

    // A new request can enter whenever the response slot is empty or is
    // being drained this same cycle; nothing is accepted during reset.
    assign req_ready = !reset && (!r_resp_valid || resp_ready);
    assign w_accept  = req_valid && req_ready;
    assign w_wr_en   = w_accept && req_write && !w_err;

    // Address decode: only aligned offsets of the three mapped registers hit.
    // NOTE: every variable driven here gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        w_sel = SEL_NONE;
        if (req_addr[2:0] == 3'b000) begin
            case (req_addr)
                ADDR_MSIP:     w_sel = SEL_MSIP;
                ADDR_MTIMECMP: w_sel = SEL_MTIMECMP;
                ADDR_MTIME:    w_sel = SEL_MTIME;
                default:       w_sel = SEL_NONE;
            endcase
        end
    end

    assign w_err = (w_sel == SEL_NONE);

    // Prescaler: mtime advances on the cycle the counter hits TICK_DIV-1.
    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_presc_nxt = w_tick ? 16'd0 : r_presc + 16'd1;
    assign w_mtime_inc = r_mtime + {63'd0, w_tick};

    // Next register values: the tick is applied first, then written lanes
    // override, so unwritten mtime lanes keep the increment.
    always_comb begin
        w_mtime_nxt    = w_mtime_inc;
        w_mtimecmp_nxt = r_mtimecmp;
        w_msip_nxt     = r_msip;
        if (w_wr_en) begin
            case (w_sel)
                SEL_MSIP:     if (req_strb[0]) w_msip_nxt = req_wdata[0];
                SEL_MTIMECMP: w_mtimecmp_nxt = merge_bytes(r_mtimecmp, req_wdata, req_strb);
                SEL_MTIME:    w_mtime_nxt    = merge_bytes(w_mtime_inc, req_wdata, req_strb);
                default:      ;
            endcase
        end
    end

    // Read mux returns the pre-update value of the selected register.
    always_comb begin
        w_rdata_sel = 64'd0;
        case (w_sel)
            SEL_MSIP:     w_rdata_sel = {63'd0, r_msip};
            SEL_MTIMECMP: w_rdata_sel = r_mtimecmp;
            SEL_MTIME:    w_rdata_sel = r_mtime;
            default:      w_rdata_sel = 64'd0;
        endcase
    end

    // Timer, compare, msip and timer-interrupt state.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_presc    <= 16'd0;
            r_trint    <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_msip     <= w_msip_nxt;
            r_presc    <= w_presc_nxt;
            r_trint    <= (w_mtime_nxt >= w_mtimecmp_nxt);
        end
    end

    // Response slot: loaded on acceptance, held until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= req_write ? 64'd0 : w_rdata_sel;
            r_resp_err   <= w_err;
        end else if (r_resp_valid && resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
        end
    end

    // External interrupt synchronizer chain.
    // NOTE: the synchronizer flops are reset too, so exint is a known 0 right
    // after reset rather than whatever the chain powered up with.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[EXT_SYNC_STAGES-2:0], exint_raw};
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign trint      = r_trint;
    assign swint      = r_msip;
    assign exint      = r_sync[EXT_SYNC_STAGES-1];

endmodule

// File: tb/tb_clint_unit.sv
// tb_clint_unit: drives two clint_unit instances (TICK_DIV=1/SYNC=2 and
// TICK_DIV=4/SYNC=3) with identical MMIO traffic and compares them against a
// cycle-level behavioural model; read responses go through per-instance
// scoreboard queues.
module tb_clint_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic        resp_ready;
    logic        exint_raw;

    logic [1:0]  d_req_ready;
    logic [1:0]  d_resp_valid;
    logic [1:0]  d_resp_err;
    logic [1:0]  d_trint;
    logic [1:0]  d_swint;
    logic [1:0]  d_exint;
    logic [63:0] d_resp_rdata [2];

    clint_unit #(.TICK_DIV(1), .EXT_SYNC_STAGES(2)) u_dut_div1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(d_req_ready[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(d_resp_valid[0]), .resp_ready(resp_ready),
        .resp_rdata(d_resp_rdata[0]), .resp_err(d_resp_err[0]),
        .exint_raw(exint_raw), .trint(d_trint[0]), .swint(d_swint[0]), .exint(d_exint[0])
    );

    clint_unit #(.TICK_DIV(4), .EXT_SYNC_STAGES(3)) u_dut_div4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(d_req_ready[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(d_resp_valid[1]), .resp_ready(resp_ready),
        .resp_rdata(d_resp_rdata[1]), .resp_err(d_resp_err[1]),
        .exint_raw(exint_raw), .trint(d_trint[1]), .swint(d_swint[1]), .exint(d_exint[1])
    );

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb_q0[$];
    resp_t sb_q1[$];

    // Behavioural model state
    logic [63:0] m_time  [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];
    logic        m_trint [2];
    int          m_presc [2];
    logic        m_rv;
    logic [3:0]  m_hist;

    int n_cmp     = 0;
    int n_bad     = 0;
    int n_dut_acc = 0;
    int cyc       = 0;
    int ex_hi0    = 0;
    logic last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int td_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int ss_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic logic [63:0] lane_write(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] r;
        r = old_v;
        for (int i = 0; i < 8; i++) if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    // One clock cycle: check pre-edge outputs, predict, advance, check post-edge.
    task automatic cycle();
        logic        acc, err, tick, was_rst, n_rv;
        logic [63:0] t, c, rd;
        logic        ms;
        resp_t       r;
        logic [63:0] n_time [2];
        logic [63:0] n_cmpv [2];
        logic        n_msip [2];
        logic        n_trint[2];
        int          n_presc[2];
        logic [3:0]  n_hist;

        #1;
        acc     = 1'b0;
        was_rst = reset;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("req_ready[%0d]", k), d_req_ready[k], !m_rv || resp_ready);
                check($sformatf("resp_valid[%0d]", k), d_resp_valid[k], m_rv);
                if (d_resp_valid[k]) begin
                    if (((k == 0) ? sb_q0.size() : sb_q1.size()) == 0) begin
                        check($sformatf("resp_unexpected[%0d]", k), d_resp_valid[k], 1'b0);
                    end else begin
                        r = (k == 0) ? sb_q0[0] : sb_q1[0];
                        check($sformatf("resp_rdata[%0d]", k), d_resp_rdata[k], r.rdata);
                        check($sformatf("resp_err[%0d]", k), d_resp_err[k], r.err);
                        if (resp_ready) begin
                            if (k == 0) void'(sb_q0.pop_front());
                            else        void'(sb_q1.pop_front());
                        end
                    end
                end
            end
            acc = req_valid && (!m_rv || resp_ready);
            if (req_valid && d_req_ready[0]) n_dut_acc++;
        end
        last_acc = acc;

        err = !(req_addr == 16'h0000 || req_addr == 16'h4000 || req_addr == 16'hBFF8);
        for (int k = 0; k < 2; k++) begin
            tick       = (m_presc[k] == td_of(k) - 1);
            n_presc[k] = tick ? 0 : m_presc[k] + 1;
            t  = m_time[k] + (tick ? 64'd1 : 64'd0);
            c  = m_cmp[k];
            ms = m_msip[k];
            if (acc) begin
                rd = 64'd0;
                if (!req_write && !err) begin
                    if (req_addr == 16'h0000)      rd = {63'd0, m_msip[k]};
                    else if (req_addr == 16'h4000) rd = m_cmp[k];
                    else                           rd = m_time[k];
                end
                r.rdata = rd;
                r.err   = err;
                if (k == 0) sb_q0.push_back(r);
                else        sb_q1.push_back(r);
                if (req_write && !err) begin
                    if (req_addr == 16'h0000)      begin if (req_strb[0]) ms = req_wdata[0]; end
                    else if (req_addr == 16'h4000) c = lane_write(c, req_wdata, req_strb);
                    else                           t = lane_write(t, req_wdata, req_strb);
                end
            end
            n_time[k]  = t;
            n_cmpv[k]  = c;
            n_msip[k]  = ms;
            n_trint[k] = (t >= c);
        end
        n_hist = {m_hist[2:0], exint_raw};
        n_rv   = acc ? 1'b1 : ((m_rv && resp_ready) ? 1'b0 : m_rv);

        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                n_time[k] = 64'd0; n_cmpv[k] = '1; n_msip[k] = 1'b0;
                n_trint[k] = 1'b0; n_presc[k] = 0;
            end
            n_hist = 4'd0;
            n_rv   = 1'b0;
            sb_q0.delete();
            sb_q1.delete();
        end

        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            m_time[k] = n_time[k]; m_cmp[k] = n_cmpv[k]; m_msip[k] = n_msip[k];
            m_trint[k] = n_trint[k]; m_presc[k] = n_presc[k];
        end
        m_hist = n_hist;
        m_rv   = n_rv;
        if (d_exint[0]) ex_hi0++;

        for (int k = 0; k < 2; k++) begin
            check($sformatf("trint[%0d]", k), d_trint[k], m_trint[k]);
            check($sformatf("swint[%0d]", k), d_swint[k], m_msip[k]);
            check($sformatf("exint[%0d]", k), d_exint[k], m_hist[ss_of(k)-1]);
            if (was_rst) begin
                check($sformatf("rst_resp_valid[%0d]", k), d_resp_valid[k], 1'b0);
                check($sformatf("rst_resp_rdata[%0d]", k), d_resp_rdata[k], 64'd0);
                check($sformatf("rst_resp_err[%0d]", k), d_resp_err[k], 1'b0);
            end
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) cycle();
    endtask

    // Present a request and hold it until the model sees it accepted.
    task automatic send(input logic wr, input logic [15:0] a,
                        input logic [63:0] d, input logic [7:0] s);
        int guard;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        guard     = 0;
        last_acc  = 1'b0;
        while (!last_acc && guard < 20) begin
            cycle();
            guard++;
        end
        if (!last_acc) check("accept_timeout", guard, 0);
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        req_valid = 1'b0;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 16'h0;
        req_wdata  = 64'h0;
        req_strb   = 8'h0;
        resp_ready = 1'b1;
        exint_raw  = 1'b0;
        m_rv       = 1'b0;
        m_hist     = 4'd0;

        do_reset(3);
        idle(1);

        // Timer compare: rise when mtime reaches 5, clear by raising mtimecmp
        send(1'b1, 16'h4000, 64'd5, 8'hFF);
        idle(10);
        send(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        idle(2);

        // Software interrupt bit
        send(1'b1, 16'h0000, 64'h0000_0000_FFFF_FFFF, 8'h01);
        idle(1);
        send(1'b0, 16'h0000, 64'd0, 8'h00);
        send(1'b1, 16'h0000, 64'd0, 8'h01);
        idle(2);

        // Error accesses, then confirm nothing moved
        send(1'b0, 16'h4004, 64'd0, 8'h00);
        send(1'b0, 16'h1000, 64'd0, 8'h00);
        send(1'b1, 16'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        send(1'b0, 16'h0000, 64'd0, 8'h00);
        send(1'b0, 16'h4000, 64'd0, 8'h00);
        idle(1);

        // Partial strobe into mtimecmp, read back
        send(1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'h0F);
        send(1'b0, 16'h4000, 64'd0, 8'h00);
        idle(1);

        // Back-to-back: three requests in three cycles
        c0 = cyc;
        send(1'b0, 16'h0000, 64'd0, 8'h00);
        send(1'b0, 16'h4000, 64'd0, 8'h00);
        send(1'b0, 16'hBFF8, 64'd0, 8'h00);
        check("b2b_cycles", cyc - c0, 3);
        idle(1);

        // Backpressure: one accepted, then the slot stays full for 3 cycles
        resp_ready = 1'b0;
        c0 = n_dut_acc;
        send(1'b0, 16'h4000, 64'd0, 8'h00);
        req_addr = 16'hBFF8;
        repeat (3) cycle();
        check("hold_accepts", n_dut_acc - c0, 1);
        resp_ready = 1'b1;
        send(1'b0, 16'hBFF8, 64'd0, 8'h00);
        idle(2);

        // mtime wrap and a partial write landing on a tick cycle
        send(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        idle(5);
        send(1'b0, 16'hBFF8, 64'd0, 8'h00);
        send(1'b1, 16'hBFF8, 64'h0000_0000_0000_00AA, 8'h01);
        send(1'b0, 16'hBFF8, 64'd0, 8'h00);
        idle(2);

        // External interrupt pulse of 3 cycles
        ex_hi0    = 0;
        exint_raw = 1'b1;
        idle(3);
        exint_raw = 1'b0;
        idle(8);
        check("exint_width", ex_hi0, 3);

        // Reset with a response still pending
        resp_ready = 1'b0;
        send(1'b0, 16'h4000, 64'd0, 8'h00);
        req_valid = 1'b1;
        reset     = 1'b1;
        cycle();
        reset      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        idle(2);

        // Free-running timer: reset, 40 idle cycles, read mtime
        do_reset(1);
        idle(40);
        send(1'b0, 16'hBFF8, 64'd0, 8'h00);
        idle(3);

        check("sb_drained0", sb_q0.size(), 0);
        check("sb_drained1", sb_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
